// File: rtl/bp_nonsynth_mem_latency_pipe_if.sv
// rtl/bp_nonsynth_mem_latency_pipe_if.sv - ready/valid in, valid/yumi out link for the latency pipe
// Signal names are seen from the pipe: *_i are driven into it, *_o come out of it.
interface bp_nonsynth_mem_latency_pipe_if #(
  parameter int width_p = 512
);
  logic [width_p-1:0] data_i;
  logic               v_i;
  logic               ready_o;
  logic [width_p-1:0] data_o;
  logic               v_o;
  logic               yumi_i;

  modport master (
    output data_i, v_i, yumi_i,
    input  ready_o, data_o, v_o
  );

  modport slave (
    input  data_i, v_i, yumi_i,
    output ready_o, data_o, v_o
  );
endinterface

// File: rtl/bp_nonsynth_mem_latency_pipe.sv
// rtl/bp_nonsynth_mem_latency_pipe.sv - order-preserving fixed-latency delay buffer for memory commands
// Every accepted entry counts down from latency_p-1 and may leave only once its counter is zero.
module bp_nonsynth_mem_latency_pipe #(
  parameter int width_p         = 512,
  parameter int els_p           = 8,
  parameter int latency_p       = 16,
  parameter bit report_errors_p = 1'b1,
  localparam int ptr_w_lp       = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int cnt_w_lp       = $clog2(els_p + 1),
  localparam int cd_w_lp        = (latency_p > 1) ? $clog2(latency_p + 1) : 1
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  bp_nonsynth_mem_latency_pipe_if.slave  link_if,
  output logic [cnt_w_lp-1:0]            count_o,
  output logic                           overflow_o
);

  logic [width_p-1:0] mem_q [els_p];
  logic [cd_w_lp-1:0] cd_q  [els_p];
  logic [cd_w_lp-1:0] cd_d  [els_p];
  logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                stall_q, stall_d;
  logic [width_p-1:0]  stall_data_q;

  logic [els_p-1:0]    occ;
  logic [ptr_w_lp-1:0] offs;
  logic                ready, valid, enq, deq, illegal_yumi, hold_viol;

  always_comb begin
    ready        = (count_q != cnt_w_lp'(els_p));
    valid        = (count_q != '0) && (cd_q[rd_ptr_q] == '0);
    enq          = link_if.v_i & ready;
    deq          = link_if.yumi_i & valid;
    illegal_yumi = link_if.yumi_i & ~valid;
    // A producer stalled last cycle must present the same payload while v_i stays high.
    hold_viol    = stall_q & link_if.v_i & (link_if.data_i != stall_data_q);
    stall_d      = link_if.v_i & ~ready;
    overflow_d   = overflow_q | illegal_yumi | hold_viol;
    wr_ptr_d     = wr_ptr_q + ptr_w_lp'(enq);
    rd_ptr_d     = rd_ptr_q + ptr_w_lp'(deq);
    count_d      = count_q + cnt_w_lp'(enq) - cnt_w_lp'(deq);
  end

  // Occupancy comes from the distance to the read pointer, so full and empty never alias.
  always_comb begin
    offs = '0;
    occ  = '0;
    for (int i = 0; i < els_p; i++) begin
      offs   = ptr_w_lp'(i) - rd_ptr_q;
      occ[i] = (cnt_w_lp'(offs) < count_q);
    end
  end

  always_comb begin
    for (int i = 0; i < els_p; i++) begin
      cd_d[i] = cd_q[i];
      if (enq && (wr_ptr_q == ptr_w_lp'(i))) begin
        cd_d[i] = cd_w_lp'(latency_p - 1);
      end else if (occ[i] && (cd_q[i] != '0)) begin
        cd_d[i] = cd_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      stall_q    <= 1'b0;
      for (int i = 0; i < els_p; i++) begin
        cd_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      stall_q    <= stall_d;
      for (int i = 0; i < els_p; i++) begin
        cd_q[i] <= cd_d[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    stall_data_q <= link_if.data_i;
    if (enq) begin
      mem_q[wr_ptr_q] <= link_if.data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (report_errors_p && !reset_i && overflow_d && !overflow_q) begin
      $error("bp_nonsynth_mem_latency_pipe: protocol error flagged at time %0t", $time);
    end
  end

  assign link_if.ready_o = ready;
  assign link_if.v_o     = valid;
  assign link_if.data_o  = mem_q[rd_ptr_q];
  assign count_o         = count_q;
  assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_bp_nonsynth_mem_latency_pipe.sv
// tb/tb_bp_nonsynth_mem_latency_pipe.sv - directed vector bench for the latency pipe
module tb_bp_nonsynth_mem_latency_pipe;
  localparam int W   = 16;
  localparam int ELS = 4;
  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic [2:0] count_o;
  logic       overflow_o;
  int         tests = 0;
  int         fails = 0;

  bp_nonsynth_mem_latency_pipe_if #(.width_p(W)) link_if ();

  bp_nonsynth_mem_latency_pipe #(
    .width_p(W), .els_p(ELS), .latency_p(LAT), .report_errors_p(1'b0)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .link_if(link_if.slave),
    .count_o(count_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        y;
    logic        ev;
    logic [15:0] ed;
    logic        er;
    logic [2:0]  ec;
    logic        eo;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic y);
    link_if.v_i    = v;
    link_if.data_i = d;
    link_if.yumi_i = y;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1;
    drive(1'b0, 16'h0, 1'b0);
    @(negedge clk);
    reset_i = 1'b0;
  endtask

  initial begin
    logic [15:0] nxt;
    logic [15:0] q [$];
    int sent, got, saw;
    logic phase, acc, y;

    //                 v  d       y  ev ed     er ec eo
    vecs[0]  = '{1'b1, 16'hA5, 1'b0, 1'b0, 16'h0,  1'b1, 3'd0, 1'b0};
    vecs[1]  = '{1'b0, 16'h0,  1'b0, 1'b0, 16'h0,  1'b1, 3'd1, 1'b0};
    vecs[2]  = '{1'b0, 16'h0,  1'b0, 1'b0, 16'h0,  1'b1, 3'd1, 1'b0};
    vecs[3]  = '{1'b0, 16'h0,  1'b0, 1'b0, 16'h0,  1'b1, 3'd1, 1'b0};
    vecs[4]  = '{1'b0, 16'h0,  1'b1, 1'b1, 16'hA5, 1'b1, 3'd1, 1'b0};
    vecs[5]  = '{1'b0, 16'h0,  1'b0, 1'b0, 16'h0,  1'b1, 3'd0, 1'b0};
    vecs[6]  = '{1'b1, 16'h1,  1'b0, 1'b0, 16'h0,  1'b1, 3'd0, 1'b0};
    vecs[7]  = '{1'b1, 16'h2,  1'b0, 1'b0, 16'h0,  1'b1, 3'd1, 1'b0};
    vecs[8]  = '{1'b1, 16'h3,  1'b0, 1'b0, 16'h0,  1'b1, 3'd2, 1'b0};
    vecs[9]  = '{1'b0, 16'h0,  1'b0, 1'b0, 16'h0,  1'b1, 3'd3, 1'b0};
    vecs[10] = '{1'b0, 16'h0,  1'b1, 1'b1, 16'h1,  1'b1, 3'd3, 1'b0};
    vecs[11] = '{1'b0, 16'h0,  1'b1, 1'b1, 16'h2,  1'b1, 3'd2, 1'b0};
    vecs[12] = '{1'b0, 16'h0,  1'b1, 1'b1, 16'h3,  1'b1, 3'd1, 1'b0};
    vecs[13] = '{1'b0, 16'h0,  1'b0, 1'b0, 16'h0,  1'b1, 3'd0, 1'b0};

    drive(1'b0, 16'h0, 1'b0);
    do_reset();

    // single item then back-to-back, one vector per cycle
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].y);
      #1;
      chk($sformatf("vec%0d v_o", i), 32'(link_if.v_o), 32'(vecs[i].ev));
      if (vecs[i].ev) chk($sformatf("vec%0d data_o", i), 32'(link_if.data_o), 32'(vecs[i].ed));
      chk($sformatf("vec%0d ready_o", i), 32'(link_if.ready_o), 32'(vecs[i].er));
      chk($sformatf("vec%0d count_o", i), 32'(count_o), 32'(vecs[i].ec));
      chk($sformatf("vec%0d overflow_o", i), 32'(overflow_o), 32'(vecs[i].eo));
      @(negedge clk);
    end

    // fill and backpressure
    do_reset();
    nxt = 16'h100;
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, nxt, 1'b0);
      #1;
      chk($sformatf("fill c%0d ready_o", c), 32'(link_if.ready_o), (c < 4) ? 32'd1 : 32'd0);
      if (c == 4) chk("fill count full", 32'(count_o), 32'd4);
      if (link_if.ready_o) nxt++;
      @(negedge clk);
    end
    drive(1'b1, nxt, 1'b1);
    #1;
    chk("fill head v_o", 32'(link_if.v_o), 32'd1);
    chk("fill head data", 32'(link_if.data_o), 32'h100);
    @(negedge clk);
    drive(1'b1, nxt, 1'b0);
    #1;
    chk("fill ready after deq", 32'(link_if.ready_o), 32'd1);
    chk("fill count after deq", 32'(count_o), 32'd3);
    nxt++;
    @(negedge clk);
    drive(1'b1, nxt, 1'b0);
    #1;
    chk("fill count refilled", 32'(count_o), 32'd4);
    chk("fill ready refilled", 32'(link_if.ready_o), 32'd0);
    chk("fill new head", 32'(link_if.data_o), 32'h101);
    chk("fill no overflow", 32'(overflow_o), 32'd0);
    @(negedge clk);
    // payload changes while stalled -> hold violation
    drive(1'b1, 16'h1FF, 1'b0);
    #1;
    chk("hold pre overflow", 32'(overflow_o), 32'd0);
    @(negedge clk);
    drive(1'b0, 16'h0, 1'b0);
    #1;
    chk("hold overflow set", 32'(overflow_o), 32'd1);

    // wrap-around streaming with toggling consumer
    do_reset();
    sent = 0; got = 0; phase = 1'b1;
    for (int c = 0; c < 400 && got < 20; c++) begin
      drive(sent < 20, 16'(16'h200 + sent), 1'b0);
      #1;
      acc = link_if.v_i & link_if.ready_o;
      y = phase & link_if.v_o;
      link_if.yumi_i = y;
      if (y) begin
        if (q.size() == 0) begin
          chk("wrap spurious output", 32'(link_if.data_o), 32'hFFFF_FFFF);
        end else begin
          chk($sformatf("wrap item%0d", got), 32'(link_if.data_o), 32'(q.pop_front()));
        end
        got++;
      end
      if (acc) begin
        q.push_back(16'(16'h200 + sent));
        sent++;
      end
      phase = ~phase;
      @(negedge clk);
    end
    drive(1'b0, 16'h0, 1'b0);
    #1;
    chk("wrap items received", 32'(got), 32'd20);
    chk("wrap count drained", 32'(count_o), 32'd0);
    chk("wrap no overflow", 32'(overflow_o), 32'd0);

    // mid-operation reset
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 16'(16'h51 + c), 1'b0);
      @(negedge clk);
    end
    drive(1'b0, 16'h0, 1'b0);
    #1;
    chk("mid count before reset", 32'(count_o), 32'd3);
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    chk("mid count after reset", 32'(count_o), 32'd0);
    chk("mid v_o after reset", 32'(link_if.v_o), 32'd0);
    chk("mid ready after reset", 32'(link_if.ready_o), 32'd1);
    saw = 0;
    for (int c = 0; c < 2 * LAT; c++) begin
      @(negedge clk);
      #1;
      if (link_if.v_o) saw++;
    end
    chk("mid no stale output", 32'(saw), 32'd0);

    // illegal yumi while empty
    do_reset();
    drive(1'b0, 16'h0, 1'b1);
    #1;
    chk("illegal pre overflow", 32'(overflow_o), 32'd0);
    @(negedge clk);
    drive(1'b1, 16'h3C, 1'b0);
    #1;
    chk("illegal overflow set", 32'(overflow_o), 32'd1);
    chk("illegal count unchanged", 32'(count_o), 32'd0);
    @(negedge clk);
    drive(1'b0, 16'h0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("illegal wait c%0d v_o", c), 32'(link_if.v_o), 32'd0);
      @(negedge clk);
    end
    #1;
    chk("illegal item v_o", 32'(link_if.v_o), 32'd1);
    chk("illegal item data", 32'(link_if.data_o), 32'h3C);
    link_if.yumi_i = 1'b1;
    @(negedge clk);
    link_if.yumi_i = 1'b0;
    #1;
    chk("illegal overflow held", 32'(overflow_o), 32'd1);
    chk("illegal count after deq", 32'(count_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
